// File: rtl/uart_axi_streamer_pkg.sv
// rtl/uart_axi_streamer_pkg.sv - register offsets, response codes and FSM types for the uart streamer
package uart_axi_pkg;

  localparam logic [7:0] OFS_DIV    = 8'h00;
  localparam logic [7:0] OFS_TXDATA = 8'h10;
  localparam logic [7:0] OFS_STATUS = 8'h14;
  localparam logic [7:0] OFS_MODE   = 8'h1C;

  localparam int         STATUS_TXFULL_BIT = 1;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_RESP
  } state_t;

  typedef enum logic [1:0] {
    K_CFG_DIV,
    K_CFG_MODE,
    K_TX
  } kind_t;

endpackage

// File: rtl/uart_axi_streamer_if.sv
// rtl/uart_axi_streamer_if.sv - AXI4 bus between the streamer (master) and the uart register slave
interface uart_axi_streamer_if #(
  parameter int ALEN  = 32,
  parameter int XLEN  = 32,
  parameter int IDLEN = 5
);
  logic             aw_valid, aw_ready;
  logic [IDLEN-1:0] aw_id;
  logic [ALEN-1:0]  aw_addr;
  logic [7:0]       aw_len;
  logic [2:0]       aw_size;
  logic [1:0]       aw_burst;
  logic [2:0]       aw_prot;

  logic              w_valid, w_ready;
  logic [XLEN-1:0]   w_data;
  logic [XLEN/8-1:0] w_strb;
  logic              w_last;

  logic             b_valid, b_ready;
  logic [IDLEN-1:0] b_id;
  logic [1:0]       b_resp;

  logic             ar_valid, ar_ready;
  logic [IDLEN-1:0] ar_id;
  logic [ALEN-1:0]  ar_addr;
  logic [7:0]       ar_len;
  logic [2:0]       ar_size;
  logic [1:0]       ar_burst;
  logic [2:0]       ar_prot;

  logic             r_valid, r_ready;
  logic [IDLEN-1:0] r_id;
  logic [XLEN-1:0]  r_data;
  logic [1:0]       r_resp;
  logic             r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input  b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, input ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, input r_ready
  );
endinterface

// File: rtl/uart_axi_streamer.sv
// rtl/uart_axi_streamer.sv - AXI4 master that configures a uart and streams bytes into its TX FIFO
module uart_axi_streamer
  import uart_axi_pkg::*;
#(
  parameter int              ALEN     = 32,
  parameter int              XLEN     = 32,
  parameter logic [ALEN-1:0] REGMAP   = 'h1_0000,
  parameter int              POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_divider,
  input  logic [31:0] cfg_mode,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        configured,
  output logic        busy,
  output logic        err,
  uart_axi_streamer_if.master bus
);
  localparam int PW = $clog2(POLL_MAX + 1);

  state_t          r_state, w_state_nxt;
  kind_t           r_kind;
  logic [ALEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [31:0]     r_mode;
  logic [7:0]      r_byte;
  logic [PW-1:0]   r_poll_cnt;
  logic            r_configured, r_err, r_aw_done, r_w_done;

  logic          w_accept, w_b_ok, w_r_ok, w_tx_full, w_poll_last;
  logic [PW-1:0] w_poll_inc;
  logic          w_unused;

  assign w_accept    = (r_state == S_IDLE) && !cfg_start && r_configured && !r_err && s_valid;
  assign w_b_ok      = (bus.b_resp == AXI_RESP_OKAY);
  assign w_r_ok      = (bus.r_resp == AXI_RESP_OKAY);
  assign w_tx_full   = bus.r_data[STATUS_TXFULL_BIT];
  assign w_poll_inc  = r_poll_cnt + PW'(1);
  assign w_poll_last = (w_poll_inc == PW'(POLL_MAX));
  assign w_unused    = ^{bus.b_id, bus.r_id, bus.r_last, bus.r_data};

  assign s_ready    = w_accept;
  assign busy       = (r_state != S_IDLE);
  assign configured = r_configured;
  assign err        = r_err;

  assign bus.aw_id    = '0;
  assign bus.aw_addr  = r_addr;
  assign bus.aw_len   = '0;
  assign bus.aw_size  = 3'($clog2(XLEN / 8));
  assign bus.aw_burst = 2'b01;
  assign bus.aw_prot  = '0;
  assign bus.w_data   = r_data;
  assign bus.w_strb   = '1;
  assign bus.w_last   = 1'b1;
  assign bus.ar_id    = '0;
  assign bus.ar_addr  = REGMAP + ALEN'(OFS_STATUS);
  assign bus.ar_len   = '0;
  assign bus.ar_size  = 3'($clog2(XLEN / 8));
  assign bus.ar_burst = 2'b01;
  assign bus.ar_prot  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Each write channel drops its valid once accepted; the phase ends when both are done.
  always_comb begin
    w_state_nxt  = r_state;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0;
    bus.r_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start)     w_state_nxt = S_WR_ADDR;
        else if (w_accept) w_state_nxt = S_RD_ADDR;
      end
      S_WR_ADDR: begin
        bus.aw_valid = !r_aw_done;
        bus.w_valid  = !r_w_done;
        if ((r_aw_done || bus.aw_ready) && (r_w_done || bus.w_ready)) w_state_nxt = S_WR_RESP;
        else if (r_aw_done || bus.aw_ready)                           w_state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus.w_valid = 1'b1;
        if (bus.w_ready) w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        bus.b_ready = 1'b1;
        if (bus.b_valid) begin
          if (w_b_ok && (r_kind == K_CFG_DIV)) w_state_nxt = S_WR_ADDR;
          else                                 w_state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        bus.ar_valid = 1'b1;
        if (bus.ar_ready) w_state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        bus.r_ready = 1'b1;
        if (bus.r_valid) begin
          if (!w_r_ok)         w_state_nxt = S_IDLE;
          else if (!w_tx_full) w_state_nxt = S_WR_ADDR;
          else if (w_poll_last) w_state_nxt = S_IDLE;
          else                 w_state_nxt = S_RD_ADDR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind       <= K_CFG_DIV;
      r_addr       <= '0;
      r_data       <= '0;
      r_mode       <= '0;
      r_byte       <= '0;
      r_poll_cnt   <= '0;
      r_configured <= 1'b0;
      r_err        <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_configured <= 1'b0;
            r_err        <= 1'b0;
            r_kind       <= K_CFG_DIV;
            r_addr       <= REGMAP + ALEN'(OFS_DIV);
            r_data       <= XLEN'(cfg_divider);
            r_mode       <= cfg_mode;
          end else if (w_accept) begin
            r_byte     <= s_data;
            r_poll_cnt <= '0;
          end
        end
        S_WR_ADDR: begin
          if (w_state_nxt == S_WR_ADDR) begin
            r_aw_done <= r_aw_done || bus.aw_ready;
            r_w_done  <= r_w_done || bus.w_ready;
          end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WR_RESP: begin
          if (bus.b_valid) begin
            if (!w_b_ok) begin
              r_err <= 1'b1;
            end else if (r_kind == K_CFG_DIV) begin
              r_kind <= K_CFG_MODE;
              r_addr <= REGMAP + ALEN'(OFS_MODE);
              r_data <= XLEN'(r_mode);
            end else if (r_kind == K_CFG_MODE) begin
              r_configured <= 1'b1;
            end
          end
        end
        S_RD_RESP: begin
          if (bus.r_valid) begin
            if (!w_r_ok) begin
              r_err <= 1'b1;
            end else if (!w_tx_full) begin
              r_kind <= K_TX;
              r_addr <= REGMAP + ALEN'(OFS_TXDATA);
              r_data <= XLEN'(r_byte);
            end else begin
              r_poll_cnt <= w_poll_inc;
              if (w_poll_last) r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_axi_streamer.sv
// tb/tb_uart_axi_streamer.sv - randomized bench with AXI slave model and a transaction-level scoreboard
module tb_uart_axi_streamer;
  localparam logic [31:0] BASE   = 32'h1_0000;
  localparam logic [31:0] A_DIV  = BASE + 32'h00;
  localparam logic [31:0] A_TX   = BASE + 32'h10;
  localparam logic [31:0] A_MODE = BASE + 32'h1C;
  localparam int          PMAX   = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_divider = '0;
  logic [31:0] cfg_mode = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, configured, busy, err;

  uart_axi_streamer_if #(.ALEN(32), .XLEN(32), .IDLEN(5)) ax ();

  uart_axi_streamer #(.ALEN(32), .XLEN(32), .REGMAP(BASE), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_divider(cfg_divider),
    .cfg_mode(cfg_mode), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .configured(configured), .busy(busy), .err(err), .bus(ax.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model state and scoreboard
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [31:0] st_q[$];
  int          rd_cnt = 0;
  int          hs_mode = 0;
  bit          inj_slverr = 0;
  bit          r_hold = 0;

  bit          aw_got, w_got, ar_pend;
  logic [31:0] sv_aw, sv_wd;
  int          aw_fires, w_fires, ph_cnt;
  bit          f_aw, f_w, f_b, f_ar, f_r;
  logic [31:0] cap_aw, cap_w;
  bit          p_aw_st, p_w_st, p_ar_st;
  logic [31:0] p_aw_a, p_w_d, p_ar_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      ax.aw_ready = 0; ax.w_ready = 0; ax.ar_ready = 0;
      ax.b_valid = 0; ax.b_id = '0; ax.b_resp = 2'b00;
      ax.r_valid = 0; ax.r_id = '0; ax.r_data = '0; ax.r_resp = 2'b00; ax.r_last = 1'b1;
      aw_got = 0; w_got = 0; ar_pend = 0; aw_fires = 0; w_fires = 0; ph_cnt = 0;
      f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
      p_aw_st = 0; p_w_st = 0; p_ar_st = 0;
    end else begin
      if (f_aw) begin aw_got = 1; sv_aw = cap_aw; aw_fires++; end
      if (f_w)  begin w_got = 1; sv_wd = cap_w; w_fires++; end
      if (f_b)  ax.b_valid = 0;
      if (f_ar) begin ar_pend = 1; rd_cnt++; end
      if (f_r)  ax.r_valid = 0;
      if (p_aw_st) chk("aw_hold", {ax.aw_valid, ax.aw_addr}, {1'b1, p_aw_a});
      if (p_w_st)  chk("w_hold", {ax.w_valid, ax.w_data}, {1'b1, p_w_d});
      if (p_ar_st) chk("ar_hold", {ax.ar_valid, ax.ar_addr}, {1'b1, p_ar_a});
      if (aw_got && w_got && !ax.b_valid) begin
        obs_q.push_back({sv_aw, sv_wd});
        chk("one_aw", aw_fires, 1);
        chk("one_w", w_fires, 1);
        aw_fires = 0; w_fires = 0; aw_got = 0; w_got = 0; ph_cnt = 0;
        ax.b_valid = 1;
        ax.b_resp  = (inj_slverr && sv_aw == A_MODE) ? 2'b10 : 2'b00;
      end
      if (ar_pend && !ax.r_valid && !r_hold && $urandom_range(0, 3) != 0) begin
        ax.r_valid = 1;
        ax.r_resp  = 2'b00;
        ax.r_data  = (st_q.size() != 0) ? st_q.pop_front() : 32'h0;
        ar_pend = 0;
      end
      if (ax.aw_valid || ax.w_valid) ph_cnt++;
      case (hs_mode)
        1:       begin ax.w_ready = (ph_cnt >= 1); ax.aw_ready = (ph_cnt >= 4); end
        2:       begin ax.aw_ready = (ph_cnt >= 1); ax.w_ready = (ph_cnt >= 4); end
        default: begin ax.aw_ready = 1'($urandom_range(0, 1)); ax.w_ready = 1'($urandom_range(0, 1)); end
      endcase
      ax.ar_ready = 1'($urandom_range(0, 1));
      #1;
      f_aw = ax.aw_valid && ax.aw_ready; cap_aw = ax.aw_addr;
      f_w  = ax.w_valid && ax.w_ready;   cap_w  = ax.w_data;
      f_ar = ax.ar_valid && ax.ar_ready;
      f_b  = ax.b_valid && ax.b_ready;
      f_r  = ax.r_valid && ax.r_ready;
      p_aw_st = ax.aw_valid && !ax.aw_ready; p_aw_a = ax.aw_addr;
      p_w_st  = ax.w_valid && !ax.w_ready;   p_w_d  = ax.w_data;
      p_ar_st = ax.ar_valid && !ax.ar_ready; p_ar_a = ax.ar_addr;
    end
  end

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic configure(input logic [31:0] div, input logic [31:0] mode);
    @(negedge clk);
    cfg_divider = div; cfg_mode = mode; cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    wait_idle("cfg");
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    s_data = b; s_valid = 1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (s_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      s_valid = 0;
      return;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
      chk("sready_busy", s_ready, 0);
    end
    s_valid = 0;
    if (busy) chk("byte_idle_timeout", 1, 0);
  endtask

  // Reference: a byte behind nfull TX-full replies costs min(nfull+1, PMAX) reads and is written only if nfull < PMAX
  task automatic run_byte(input logic [7:0] b, input int nfull);
    for (int i = 0; i < nfull; i++) st_q.push_back($urandom | 32'h2);
    st_q.push_back($urandom & ~32'h2);
    send_byte(b);
    if (nfull < PMAX) exp_q.push_back({A_TX, 24'h0, b});
  endtask

  function automatic int exp_reads(input int nfull);
    return (nfull < PMAX) ? nfull + 1 : PMAX;
  endfunction

  task automatic end_case(input string tag, input int n_rd);
    chk({tag, "_reads"}, rd_cnt, n_rd);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_waddr"}, obs_q[i].a, exp_q[i].a);
      chk({tag, "_wdata"}, obs_q[i].d, exp_q[i].d);
    end
    obs_q.delete(); exp_q.delete(); st_q.delete(); rd_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  hello [10] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h64};
    logic [31:0] div;
    int          nfull, nrd;
    logic [7:0]  b;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_configured", configured, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_valids", {ax.aw_valid, ax.w_valid, ax.ar_valid, ax.b_ready, ax.r_ready}, 5'b0);
    rst_n = 1;
    @(negedge clk);

    configure(32'hA2C, 32'h20);
    exp_q.push_back({A_DIV, 32'hA2C});
    exp_q.push_back({A_MODE, 32'h20});
    end_case("cfg", 0);
    chk("cfg_configured", configured, 1);
    chk("cfg_err", err, 0);

    for (int i = 0; i < 10; i++) run_byte(hello[i], 0);
    end_case("hello", 10);

    st_q.push_back(32'h2); st_q.push_back(32'h2); st_q.push_back(32'h2);
    send_byte(8'h5A);
    exp_q.push_back({A_TX, 32'h5A});
    end_case("txfull", 4);

    for (int k = 0; k < 6; k++) begin
      nfull = $urandom_range(0, 3);
      b = 8'($urandom);
      run_byte(b, nfull);
      end_case("rand", exp_reads(nfull));
    end
    chk("rand_err", err, 0);

    nfull = 6;
    nrd = exp_reads(nfull);
    run_byte(8'($urandom), nfull);
    end_case("timeout", nrd);
    chk("timeout_err", err, 1);
    chk("timeout_configured", configured, 1);
    @(negedge clk);
    s_valid = 1; s_data = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("timeout_sready", {s_ready, busy}, 2'b00);
      @(negedge clk);
    end
    s_valid = 0;
    end_case("timeout_probe", 0);

    for (int m = 1; m <= 2; m++) begin
      hs_mode = m;
      div = $urandom;
      configure(div, 32'h20);
      exp_q.push_back({A_DIV, div});
      exp_q.push_back({A_MODE, 32'h20});
      run_byte(8'($urandom), 0);
      end_case("hs_order", 1);
      chk("hs_configured", configured, 1);
      chk("hs_err", err, 0);
    end
    hs_mode = 0;

    inj_slverr = 1;
    configure(32'h1234, 32'h20);
    exp_q.push_back({A_DIV, 32'h1234});
    exp_q.push_back({A_MODE, 32'h20});
    end_case("slverr", 0);
    chk("slverr_err", err, 1);
    chk("slverr_configured", configured, 0);
    inj_slverr = 0;

    configure(32'hA2C, 32'h20);
    exp_q.push_back({A_DIV, 32'hA2C});
    exp_q.push_back({A_MODE, 32'h20});
    end_case("recfg", 0);
    chk("recfg_state", {configured, err}, 2'b10);

    r_hold = 1;
    @(negedge clk);
    s_data = 8'h33; s_valid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (ax.r_ready) break;
    end
    chk("rdresp_reached", ax.r_ready, 1);
    s_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_flags", {busy, configured, err, s_ready}, 4'b0);
    chk("midrst_bus", {ax.aw_valid, ax.w_valid, ax.ar_valid, ax.b_ready, ax.r_ready}, 5'b0);
    @(negedge clk);
    r_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("postrst_state", {busy, configured, err}, 3'b000);
    obs_q.delete(); exp_q.delete();
    chk("postrst_nwr", obs_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
